// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake and operand/result bundle for the sequential ALU.
//
// Build option: none (the multiplier option lives in rtl/alu_seq.sv).
//
// Signals (N = operand/result width):
//   start   - request; the ALU samples it only while busy=0
//   op      - 4-bit operation code, captured with start
//   in1     - operand A (accumulator side), captured with start
//   in2     - operand B, or the shift amount for shifts, captured with start
//   out     - registered result
//   V,Z,C,S - overflow, zero, carry/borrow/shift-out and sign flags
//   busy    - a multi-cycle operation is in progress
//   done    - one-cycle pulse: out and the flags were updated
//   illegal - pulses together with done when op is unsupported
//
// Modports:
//   master - the controller side that issues operations
//   slave  - the ALU itself
interface alu_seq_if #(
    parameter int N = 8
);
    logic         start;
    logic [3:0]   op;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic [N-1:0] out;
    logic         V;
    logic         Z;
    logic         C;
    logic         S;
    logic         busy;
    logic         done;
    logic         illegal;

    modport master (
        output start, op, in1, in2,
        input  out, V, Z, C, S, busy, done, illegal
    );

    modport slave (
        input  start, op, in1, in2,
        output out, V, Z, C, S, busy, done, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a start/busy/done handshake.
//
// Single-cycle ops (ADD, SUB, OR, AND, NOT, PASS, trivial shifts, unsupported
// codes) finish in the cycle after start is sampled. Shifts by 1 < k < N
// iterate one bit per cycle in the SHIFT state. With the build macro
// ALU_SEQ_MUL_EN defined, op 8 runs an N-iteration shift-add multiply in the
// MUL state; without it op 8 is reported as illegal and no multiplier exists.
//
// Ports:
//   clk - system clock, all state updates on the rising edge
//   rst - synchronous, active-high reset; drops any in-flight op silently
//   bus - alu_seq_if slave modport (start/op/in1/in2 in, result/flags out)
//
// Parameters:
//   N  - operand/result width (N >= 4)
//   SW - width of the iteration counter
module alu_seq #(
    parameter int N  = 8,
    parameter int SW = $clog2(N) + 1
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MUL
    } state_t;

    localparam logic [N-1:0] N_VAL = N[N-1:0];

    state_t         state_q, state_d;
    logic [N-1:0]   out_q, out_d;
    logic           v_q, v_d;
    logic           z_q, z_d;
    logic           c_q, c_d;
    logic           s_q, s_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           illegal_q, illegal_d;

    // Shift working register, direction (1 = right) and remaining-iteration count.
    logic [N-1:0]   work_q, work_d;
    logic           dir_q, dir_d;
    logic [SW-1:0]  cnt_q, cnt_d;

`ifdef ALU_SEQ_MUL_EN
    // Partial product, left-shifting multiplicand and right-shifting multiplier.
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_next;
`endif

    // Values presented to the result registers when an op finishes.
    logic           fin;
    logic [N-1:0]   res;
    logic           res_c;
    logic           res_v;
    logic           res_ill;
    logic [N:0]     sum;
    logic [N-1:0]   shifted;
    logic           shift_bit;

    // Next-state logic. The edge that captures an op already performs the first
    // iteration of a shift or multiply, so a k-step shift finishes k cycles
    // after start and a 1-step shift lines up with the single-cycle ops.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        v_d       = v_q;
        z_d       = z_q;
        c_d       = c_q;
        s_d       = s_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        work_d    = work_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_next  = '0;
`endif
        fin       = 1'b0;
        res       = '0;
        res_c     = 1'b0;
        res_v     = 1'b0;
        res_ill   = 1'b0;
        sum       = '0;
        shifted   = '0;
        shift_bit = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        4'd0: begin
                            sum   = {1'b0, bus.in1} + {1'b0, bus.in2};
                            res   = sum[N-1:0];
                            res_c = sum[N];
                            // Same-signed operands giving an opposite-signed sum.
                            res_v = (bus.in1[N-1] == bus.in2[N-1]) && (res[N-1] != bus.in1[N-1]);
                            fin   = 1'b1;
                        end
                        4'd1: begin
                            res   = bus.in1 - bus.in2;
                            res_c = (bus.in1 < bus.in2);
                            res_v = (bus.in1[N-1] != bus.in2[N-1]) && (res[N-1] != bus.in1[N-1]);
                            fin   = 1'b1;
                        end
                        4'd2: begin
                            res = bus.in1 | bus.in2;
                            fin = 1'b1;
                        end
                        4'd3: begin
                            res = bus.in1 & bus.in2;
                            fin = 1'b1;
                        end
                        4'd4, 4'd5: begin
                            if (bus.in2 == '0) begin
                                res = bus.in1;
                                fin = 1'b1;
                            end else if (bus.in2 >= N_VAL) begin
                                fin = 1'b1;
                            end else begin
                                if (bus.op == 4'd5) begin
                                    shifted   = bus.in1 >> 1;
                                    shift_bit = bus.in1[0];
                                end else begin
                                    shifted   = bus.in1 << 1;
                                    shift_bit = bus.in1[N-1];
                                end
                                if (bus.in2 == N'(1)) begin
                                    res   = shifted;
                                    res_c = shift_bit;
                                    fin   = 1'b1;
                                end else begin
                                    state_d = SHIFT;
                                    busy_d  = 1'b1;
                                    work_d  = shifted;
                                    dir_d   = (bus.op == 4'd5);
                                    cnt_d   = bus.in2[SW-1:0] - SW'(1);
                                end
                            end
                        end
                        4'd6: begin
                            res = ~bus.in1;
                            fin = 1'b1;
                        end
                        4'd7: begin
                            res = bus.in1;
                            fin = 1'b1;
                        end
`ifdef ALU_SEQ_MUL_EN
                        4'd8: begin
                            state_d  = MUL;
                            busy_d   = 1'b1;
                            acc_d    = bus.in2[0] ? {{N{1'b0}}, bus.in1} : '0;
                            mcand_d  = {{(N-1){1'b0}}, bus.in1, 1'b0};
                            mplier_d = bus.in2 >> 1;
                            cnt_d    = SW'(N - 1);
                        end
`endif
                        default: begin
                            res_ill = 1'b1;
                            fin     = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                if (dir_q) begin
                    shifted   = work_q >> 1;
                    shift_bit = work_q[0];
                end else begin
                    shifted   = work_q << 1;
                    shift_bit = work_q[N-1];
                end
                // The bit leaving on the final step is the carry.
                if (cnt_q == SW'(1)) begin
                    res     = shifted;
                    res_c   = shift_bit;
                    fin     = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    work_d = shifted;
                    cnt_d  = cnt_q - SW'(1);
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
                if (cnt_q == SW'(1)) begin
                    res     = acc_next[N-1:0];
                    res_c   = |acc_next[2*N-1:N];
                    fin     = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - SW'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Result and flags move only on completion; otherwise they hold.
        if (fin) begin
            out_d     = res;
            c_d       = res_c;
            v_d       = res_v;
            z_d       = (res == '0);
            s_d       = res[N-1];
            illegal_d = res_ill;
            done_d    = 1'b1;
        end
    end

    // State register; reset clears everything and abandons any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_q     <= '0;
            v_q       <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            s_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            work_q    <= '0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            v_q       <= v_d;
            z_q       <= z_d;
            c_q       <= c_d;
            s_q       <= s_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            work_q    <= work_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
`endif
        end
    end

    assign bus.out     = out_q;
    assign bus.V       = v_q;
    assign bus.Z       = z_q;
    assign bus.C       = c_q;
    assign bus.S       = s_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at N=8.
// Directed cases from the operation rules, mid-operation start/reset cases,
// back-to-back issue, then randomized ops compared to a behavioural model.
// Honours ALU_SEQ_MUL_EN the same way as the design.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    alu_seq_if #(.N(N)) bus ();

    alu_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock; inputs change and outputs are sampled on negedges.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] out;
        logic       c;
        logic       v;
        logic       ill;
        logic [7:0] lat;
    } exp_t;

    // Behavioural reference: results from integer arithmetic, latency in cycles.
    function automatic exp_t refModel(input int op, input int a, input int b);
        exp_t e;
        int   sa, sb, r;
        e     = '0;
        e.lat = 8'd1;
        sa    = (a >= 128) ? a - 256 : a;
        sb    = (b >= 128) ? b - 256 : b;
        case (op)
            0: begin
                r     = a + b;
                e.out = r[7:0];
                e.c   = (r > 255);
                r     = sa + sb;
                e.v   = (r > 127) || (r < -128);
            end
            1: begin
                r     = a - b + 256;
                e.out = r[7:0];
                e.c   = (a < b);
                r     = sa - sb;
                e.v   = (r > 127) || (r < -128);
            end
            2: begin r = a | b; e.out = r[7:0]; end
            3: begin r = a & b; e.out = r[7:0]; end
            4: begin
                if (b == 0) begin
                    r = a; e.out = r[7:0];
                end else if (b < 8) begin
                    r     = a * (2 ** b);
                    e.out = r[7:0];
                    e.c   = ((r / 256) % 2) == 1;
                    e.lat = 8'(b);
                end
            end
            5: begin
                if (b == 0) begin
                    r = a; e.out = r[7:0];
                end else if (b < 8) begin
                    r     = a / (2 ** b);
                    e.out = r[7:0];
                    e.c   = ((a / (2 ** (b - 1))) % 2) == 1;
                    e.lat = 8'(b);
                end
            end
            6: begin r = 255 - a; e.out = r[7:0]; end
            7: begin r = a; e.out = r[7:0]; end
`ifdef ALU_SEQ_MUL_EN
            8: begin
                r     = a * b;
                e.out = r[7:0];
                e.c   = (r >= 256);
                e.lat = 8'd8;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one request for a single clock, then scramble the operand lines.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.in1   = a;
        bus.in2   = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'($urandom);
        bus.in1   = 8'($urandom);
        bus.in2   = 8'($urandom);
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        checkValue({tag, ".out"},     32'(bus.out),     32'(e.out));
        checkValue({tag, ".V"},       32'(bus.V),       32'(e.v));
        checkValue({tag, ".C"},       32'(bus.C),       32'(e.c));
        checkValue({tag, ".Z"},       32'(bus.Z),       32'(e.out == 8'h00));
        checkValue({tag, ".S"},       32'(bus.S),       32'(e.out[7]));
        checkValue({tag, ".illegal"}, 32'(bus.illegal), 32'(e.ill));
        checkValue({tag, ".busy"},    32'(bus.busy),    32'd0);
    endtask

    // Issue one op, wait (bounded) for done, check latency and result.
    // With pulseCheck=0 the caller may issue the next op in the done cycle.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input bit pulseCheck);
        exp_t e;
        int   cyc;
        e = refModel(int'(op), int'(a), int'(b));
        applyStimulus(op, a, b);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            checkValue({tag, ".busy_wait"}, 32'(bus.busy), 32'd1);
            @(negedge clk);
            cyc++;
        end
        checkValue({tag, ".latency"}, 32'(cyc), 32'(e.lat));
        checkOutput(tag, e);
        if (pulseCheck) begin
            @(negedge clk);
            checkValue({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
            checkValue({tag, ".out_hold"},   32'(bus.out),  32'(e.out));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, ".out"},     32'(bus.out),     32'd0);
        checkValue({tag, ".flags"},   32'({bus.V, bus.Z, bus.C, bus.S}), 32'd0);
        checkValue({tag, ".busy"},    32'(bus.busy),    32'd0);
        checkValue({tag, ".done"},    32'(bus.done),    32'd0);
        checkValue({tag, ".illegal"}, 32'(bus.illegal), 32'd0);
    endtask

    initial begin
        logic [3:0] rop;
        logic [7:0] ra, rb;
        int         cyc;

        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.in1   = 8'd0;
        bus.in2   = 8'd0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed arithmetic and shifts");
        runOp("add_7f_01", 4'd0, 8'h7F, 8'h01, 1'b1);
        runOp("add_ff_01", 4'd0, 8'hFF, 8'h01, 1'b1);
        runOp("sub_03_05", 4'd1, 8'h03, 8'h05, 1'b1);
        runOp("sub_80_01", 4'd1, 8'h80, 8'h01, 1'b1);
        runOp("or",        4'd2, 8'hA0, 8'h05, 1'b1);
        runOp("and",       4'd3, 8'hF0, 8'h3C, 1'b1);
        runOp("not",       4'd6, 8'h5A, 8'h00, 1'b1);
        runOp("pass",      4'd7, 8'h81, 8'hFF, 1'b1);
        runOp("sll_81_3",  4'd4, 8'h81, 8'd3,  1'b1);
        runOp("srl_81_1",  4'd5, 8'h81, 8'd1,  1'b1);
        runOp("sll_by_9",  4'd4, 8'h81, 8'd9,  1'b1);
        runOp("srl_by_0",  4'd5, 8'hC3, 8'd0,  1'b1);
        runOp("srl_by_7",  4'd5, 8'h80, 8'd7,  1'b1);
        runOp("mul_10_11", 4'd8, 8'h10, 8'h11, 1'b1);
        runOp("mul_0f_0f", 4'd8, 8'h0F, 8'h0F, 1'b1);
        runOp("op12",      4'd12, 8'h12, 8'h34, 1'b1);

        $display("[TB] back-to-back issue");
        runOp("b2b_first",  4'd4, 8'h81, 8'd3,  1'b0);
        runOp("b2b_second", 4'd0, 8'h12, 8'h34, 1'b1);

        $display("[TB] start while busy is ignored");
        bus.start = 1'b1; bus.op = 4'd5; bus.in1 = 8'hF0; bus.in2 = 8'd6;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd0; bus.in1 = 8'h01; bus.in2 = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        checkValue("midop.ignored_done", 32'(bus.done), 32'd0);
        checkValue("midop.still_busy",   32'(bus.busy), 32'd1);
        cyc = 3;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkValue("midop.latency", 32'(cyc),    32'd6);
        checkValue("midop.out",     32'(bus.out), 32'h03);
        checkValue("midop.C",       32'(bus.C),   32'd1);
        @(negedge clk);
        checkValue("midop.no_extra_done", 32'(bus.done), 32'd0);

        $display("[TB] reset during a shift");
        bus.start = 1'b1; bus.op = 4'd5; bus.in1 = 8'hF0; bus.in2 = 8'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkValue("midreset.no_done", 32'(bus.done), 32'd0);
        end

        $display("[TB] randomized ops against the reference model");
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = (rop == 4'd4 || rop == 4'd5) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            runOp("random", rop, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
